// File: rtl/alarm_timer_pkg.sv
// alarm_timer_pkg
//   Types and constants shared by the alarm timer, the fuel pump controller and
//   the time-parameter store.
//   - state_e        : alarm timer FSM state encoding
//   - interval codes : index of each stored time parameter
//   - run_time()     : converts a stored value plus the double flag into seconds
package alarm_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int VALUE_W    = 4;
  localparam int REM_W      = 5;
  localparam int INTERVAL_W = 2;

  localparam logic [INTERVAL_W-1:0] ARM_DELAY       = 2'd0;
  localparam logic [INTERVAL_W-1:0] DRIVER_DELAY    = 2'd1;
  localparam logic [INTERVAL_W-1:0] PASSENGER_DELAY = 2'd2;
  localparam logic [INTERVAL_W-1:0] ALARM_ON        = 2'd3;

  // A doubled run time is the stored value shifted left by one; the extra
  // result bit keeps the doubled value of 15 (30 s) representable.
  function automatic logic [REM_W-1:0] run_time(input logic [VALUE_W-1:0] v,
                                                input logic               dbl);
    return dbl ? {v, 1'b0} : {1'b0, v};
  endfunction

endpackage

// File: rtl/one_hz_divider.sv
// one_hz_divider
//   Prescaler for the alarm timer: counts 0..CLK_DIV-1 while enabled and flags
//   the last count of each second.
//   clock  : system clock
//   reset  : synchronous active-high reset, counter to 0
//   clear  : synchronous counter clear (takes priority over enable)
//   enable : advance the counter this cycle
//   tick   : high during the cycle in which the counter sits at CLK_DIV-1 and
//            is enabled; the parent registers it, so the pulse it presents
//            lands on the same edge as the counter wrap
module one_hz_divider #(
  parameter int CLK_DIV = 100000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tick = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/alarm_timer.sv
// alarm_timer
//   Loads a time parameter from an external store, counts it down in seconds
//   and pulses expired when the countdown completes.
//   clock          : system clock
//   reset          : synchronous active-high reset
//   start          : single-cycle load request
//   start_interval : index of the time parameter to run
//   double         : run for twice the stored value (sampled with start)
//   cancel         : abort the countdown without expiry
//   value          : seconds from the parameter store for index 'interval'
//   interval       : index presented to the parameter store
//   busy           : high while fetching or counting
//   remaining      : seconds left, 0 when idle
//   one_hz         : one-cycle pulse at each second boundary while counting
//   expired        : one-cycle pulse when a countdown completes
// All outputs come straight from flops.
module alarm_timer
  import alarm_timer_pkg::*;
#(
  parameter int CLK_DIV = 100000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [INTERVAL_W-1:0] start_interval,
  input  logic                  double,
  input  logic                  cancel,
  input  logic [VALUE_W-1:0]    value,
  output logic [INTERVAL_W-1:0] interval,
  output logic                  busy,
  output logic [REM_W-1:0]      remaining,
  output logic                  one_hz,
  output logic                  expired
);

  state_e                state_q, state_d;
  logic [INTERVAL_W-1:0] interval_q, interval_d;
  logic                  dbl_q, dbl_d;
  logic [REM_W-1:0]      remaining_q, remaining_d;
  logic                  busy_q, busy_d;
  logic                  one_hz_q, one_hz_d;
  logic                  expired_q, expired_d;

  logic                  accept_start;
  logic                  div_en;
  logic                  div_clear;
  logic                  sec_tick;
  logic [REM_W-1:0]      run_secs;

  assign accept_start = start && !cancel;
  assign run_secs     = run_time(value, dbl_q);

  // The prescaler only runs in a COUNT cycle that is not being left through
  // cancel or retrigger; every other cycle holds it at zero, so each new
  // countdown starts from a fresh second.
  assign div_en    = (state_q == ST_COUNT) && !cancel && !start;
  assign div_clear = !div_en;

  one_hz_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clock  (clock),
    .reset  (reset),
    .clear  (div_clear),
    .enable (div_en),
    .tick   (sec_tick)
  );

  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    dbl_d       = dbl_q;
    remaining_d = remaining_q;
    one_hz_d    = 1'b0;
    // The expiry pulse is the registered image of the DONE cycle, so it is
    // emitted even when DONE is left through a retrigger.
    expired_d   = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (accept_start) begin
          interval_d = start_interval;
          dbl_d      = double;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // start is ignored here; value is valid now that interval has settled
        if (cancel) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end else begin
          remaining_d = run_secs;
          state_d     = (run_secs == '0) ? ST_DONE : ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (cancel) begin
          remaining_d = '0;
          state_d     = ST_IDLE;
        end else if (start) begin
          interval_d = start_interval;
          dbl_d      = double;
          state_d    = ST_FETCH;
        end else if (sec_tick) begin
          one_hz_d    = 1'b1;
          // remaining is at least 1 in COUNT, so this never wraps
          remaining_d = remaining_q - REM_W'(1);
          if (remaining_q == REM_W'(1)) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (accept_start) begin
          interval_d = start_interval;
          dbl_d      = double;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_COUNT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      interval_q  <= ARM_DELAY;
      dbl_q       <= 1'b0;
      remaining_q <= '0;
      busy_q      <= 1'b0;
      one_hz_q    <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      dbl_q       <= dbl_d;
      remaining_q <= remaining_d;
      busy_q      <= busy_d;
      one_hz_q    <= one_hz_d;
      expired_q   <= expired_d;
    end
  end

  assign interval  = interval_q;
  assign busy      = busy_q;
  assign remaining = remaining_q;
  assign one_hz    = one_hz_q;
  assign expired   = expired_q;

endmodule
